uart_cmd_ctrl: RTL and testbench

- Command sequencer between the UART receiver and transmitter.
- Parses 4-byte frames from the RX byte stream: SYNC, CMD, ARG, CHK.
- Executes the command against an 8-bit LED register.
- Schedules a 1- or 2-byte response into the TX handshake, pacing bytes on tx_busy.

---
 rtl/uart_cmd_pkg.sv | 13 +
 rtl/uart_cmd_txq.sv | 84 ++++++++
 rtl/uart_cmd_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared opcodes, response bytes and FSM state types
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR_LED = 8'h01;
    localparam logic [7:0] CMD_RD_LED = 8'h02;
    localparam logic [7:0] CMD_ECHO   = 8'h03;
    localparam logic [7:0] ACK_BYTE   = 8'h5A;
    localparam logic [7:0] NAK_BYTE   = 8'hEE;

    typedef enum logic [1:0] {RX_HUNT, RX_CMD, RX_ARG, RX_CHK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_GAP, TX_DRAIN} tx_state_t;

endpackage

// File: rtl/uart_cmd_txq.sv
// rtl/uart_cmd_txq.sv - 2-byte response queue and TX launch/drain handshake
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              load a new response (only asserted while busy == 0)
//   load_b0, load_b1  first and second response byte
//   load_two          1: two-byte response, 0: single byte (load_b0 only)
//   tx_busy           transmitter is shifting a byte
//   busy              a response is queued or in flight
//   tx_en             one-cycle launch strobe
//   tx_data           byte being sent, held until the next launch
module uart_cmd_txq
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_b0,
    input  logic [7:0] load_b1,
    input  logic       load_two,
    input  logic       tx_busy,
    output logic       busy,
    output logic       tx_en,
    output logic [7:0] tx_data
);

    tx_state_t  state, state_nxt;
    logic [7:0] b0, b1;
    logic [1:0] count;
    logic       pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_en     = 1'b0;
        pop       = 1'b0;
        case (state)
            TX_IDLE:   if (count != 2'd0 && !tx_busy) state_nxt = TX_LAUNCH;
            TX_LAUNCH: begin
                tx_en     = 1'b1;
                state_nxt = TX_GAP;
            end
            // The transmitter raises tx_busy a cycle after tx_en; skip one
            // sample so the old idle level is not mistaken for completion.
            TX_GAP:    state_nxt = TX_DRAIN;
            TX_DRAIN:  if (!tx_busy) begin
                pop       = 1'b1;
                state_nxt = (count == 2'd2) ? TX_LAUNCH : TX_IDLE;
            end
            default:   state_nxt = TX_IDLE;
        endcase
    end

    // Idle-with-pending also counts as busy so a new load never overwrites
    // a response that is still waiting for the transmitter.
    assign busy = (state != TX_IDLE) || (count != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b0      <= 8'h00;
            b1      <= 8'h00;
            count   <= 2'd0;
            tx_data <= 8'h00;
        end else begin
            if (load) begin
                b0    <= load_b0;
                b1    <= load_b1;
                count <= load_two ? 2'd2 : 2'd1;
            end else if (pop) begin
                b0    <= b1;
                count <= count - 2'd1;
            end
            // Capture the outgoing byte on entry to LAUNCH; when chaining from
            // DRAIN the head is popped on this same edge, so take b1.
            if (state != TX_LAUNCH && state_nxt == TX_LAUNCH)
                tx_data <= pop ? b1 : b0;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser, LED register and responder
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_valid, rx_data   received byte strobe and data
//   rx_break            BREAK from receiver, aborts any partial frame
//   tx_busy             transmitter shifting a byte
//   tx_en, tx_data      transmit launch strobe and byte
//   led                 LED register
//   frame_err           pulse on bad checksum or inter-byte timeout
//   overrun             pulse when a completed frame is dropped (TX busy)
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_HZ         = 50000000,
    parameter int         TIMEOUT_CYCLES = CLK_HZ / 100,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] LED_RESET      = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_break,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic [7:0] led,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_t     state, state_nxt;
    logic [7:0]    cmd, arg;
    logic [CW-1:0] cnt;
    logic          timeout_hit, chk_ok, frame_done, q_busy, q_load;
    logic [7:0]    resp_b0, resp_b1;
    logic          resp_two, wr_led;

    assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign chk_ok      = (rx_data == (cmd ^ arg));
    assign frame_done  = rx_valid && !rx_break && (state == RX_CHK);
    assign q_load      = frame_done && !q_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_break) begin
            state_nxt = RX_HUNT;
        end else if (rx_valid) begin
            case (state)
                RX_HUNT: if (rx_data == SYNC_BYTE) state_nxt = RX_CMD;
                RX_CMD:  state_nxt = RX_ARG;
                RX_ARG:  state_nxt = RX_CHK;
                default: state_nxt = RX_HUNT;
            endcase
        end else if (state != RX_HUNT && timeout_hit) begin
            state_nxt = RX_HUNT;
        end
    end

    always_comb begin
        resp_b0  = NAK_BYTE;
        resp_b1  = 8'h00;
        resp_two = 1'b0;
        wr_led   = 1'b0;
        if (chk_ok) begin
            case (cmd)
                CMD_WR_LED: begin resp_b0 = ACK_BYTE; resp_b1 = arg; resp_two = 1'b1; wr_led = 1'b1; end
                CMD_RD_LED: begin resp_b0 = ACK_BYTE; resp_b1 = led; resp_two = 1'b1; end
                CMD_ECHO:   begin resp_b0 = ACK_BYTE; resp_b1 = arg; resp_two = 1'b1; end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd       <= 8'h00;
            arg       <= 8'h00;
            cnt       <= '0;
            led       <= LED_RESET;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_break) begin
                cnt <= '0;
            end else if (rx_valid) begin
                cnt <= '0;
                case (state)
                    RX_CMD: cmd <= rx_data;
                    RX_ARG: arg <= rx_data;
                    RX_CHK: begin
                        if (!chk_ok) frame_err <= 1'b1;
                        // A frame landing on an in-flight response is dropped
                        // whole, LED write included.
                        if (q_busy)      overrun <= 1'b1;
                        else if (wr_led) led     <= arg;
                    end
                    default: ;
                endcase
            end else if (state != RX_HUNT) begin
                if (timeout_hit) begin
                    cnt       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    uart_cmd_txq u_txq (
        .clk      (clk),
        .reset    (reset),
        .load     (q_load),
        .load_b0  (resp_b0),
        .load_b1  (resp_b1),
        .load_two (resp_two),
        .tx_busy  (tx_busy),
        .busy     (q_busy),
        .tx_en    (tx_en),
        .tx_data  (tx_data)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam int TO       = 100;
    localparam int BUSY_CYC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_break = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [7:0] led;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .CLK_HZ         (50000000),
        .TIMEOUT_CYCLES (TO),
        .SYNC_BYTE      (8'hA5),
        .LED_RESET      (8'hF0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_break  (rx_break),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .led       (led),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame-level parse plus expected transmit byte stream.
    int         pos;
    logic [7:0] m_cmd, m_arg, m_led;
    logic [7:0] exp_q[$];
    int         n_tx_exp = 0, n_tx_seen = 0;
    int         ferr_exp = 0, ferr_seen = 0;
    int         ovr_exp = 0, ovr_seen = 0;
    bit         pending;
    int         pend_left;

    task automatic m_reset();
        pos = 0;
        m_led = 8'hF0;
        exp_q.delete();
        pending = 0;
        pend_left = 0;
    endtask

    task automatic m_push(input logic [7:0] b);
        exp_q.push_back(b);
        n_tx_exp++;
        pend_left++;
    endtask

    task automatic m_rx(input logic [7:0] b);
        if (pos == 0) begin
            if (b == 8'hA5) pos = 1;
        end else if (pos == 1) begin
            m_cmd = b; pos = 2;
        end else if (pos == 2) begin
            m_arg = b; pos = 3;
        end else begin
            pos = 0;
            if (b != (m_cmd ^ m_arg)) ferr_exp++;
            if (pending) begin
                ovr_exp++;
            end else begin
                pending = 1;
                if (b != (m_cmd ^ m_arg))  m_push(8'hEE);
                else if (m_cmd == 8'h01) begin m_push(8'h5A); m_push(m_arg); m_led = m_arg; end
                else if (m_cmd == 8'h02) begin m_push(8'h5A); m_push(m_led); end
                else if (m_cmd == 8'h03) begin m_push(8'h5A); m_push(m_arg); end
                else                       m_push(8'hEE);
            end
        end
    endtask

    // Monitor and transmitter model
    int         cyc = 0, last_rx_cyc = 0, lat = -1, busy_left = 0;
    bit         armed = 0, hold_ok = 0;
    logic       prev_tx_en = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin last_rx_cyc = cyc; armed = 1; end
        if (frame_err) ferr_seen++;
        if (overrun)   ovr_seen++;
        if (tx_en) begin
            n_tx_seen++;
            chk("tx_en_width", prev_tx_en, 0);
            if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
            if (armed) begin lat = cyc - last_rx_cyc; armed = 0; end
            if (pend_left > 0) pend_left--;
        end else if (tx_busy && hold_ok) begin
            chk("tx_hold", tx_data, cur_byte);
        end
        if (pending && pend_left == 0 && !tx_busy) pending = 0;
        prev_tx_en = tx_en;
        if (tx_en) begin
            tx_busy = 1'b1; busy_left = BUSY_CYC; cur_byte = tx_data; hold_ok = 1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1 rx_valid = 1'b1; rx_data = b; m_rx(b);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input int gap);
        send_byte(8'hA5, gap); send_byte(c, gap); send_byte(a, gap); send_byte(k, gap);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((pending || tx_busy) && t < 1000) begin @(negedge clk); t++; end
        chk("drain_bound", t < 1000, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1; hold_ok = 0;
        repeat (2) @(posedge clk);
        #1 m_reset(); reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, a, k, j;
        int         t;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 8'hF0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;

        // Write LED, check latency and response
        send_frame(8'h01, 8'h3C, 8'h3D, 0);
        wait_idle();
        chk("t1_led", led, 8'h3C);
        chk("t1_lat", lat, 2);
        chk("t1_ntx", n_tx_seen, n_tx_exp);
        chk("t1_ferr", ferr_seen, 0);

        // Read LED after reset
        do_reset();
        send_frame(8'h02, 8'h00, 8'h02, 1);
        wait_idle();
        chk("t2_led", led, 8'hF0);
        chk("t2_ntx", n_tx_seen, n_tx_exp);

        // Bad checksum
        send_frame(8'h01, 8'h3C, 8'h00, 0);
        wait_idle();
        chk("t3_led", led, 8'hF0);
        chk("t3_ferr", ferr_seen, ferr_exp);
        chk("t3_ntx", n_tx_seen, n_tx_exp);

        // Inter-byte timeout, then a good echo frame
        send_byte(8'h00, 0); send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h77, 0);
        repeat (TO + 10) @(posedge clk);
        pos = 0; ferr_exp++;
        chk("t4_ferr", ferr_seen, ferr_exp);
        chk("t4_ntx_silent", n_tx_seen, n_tx_exp);
        send_frame(8'h03, 8'h77, 8'h74, 0);
        wait_idle();
        chk("t4_ntx", n_tx_seen, n_tx_exp);

        // Second frame completes while first response is draining
        send_frame(8'h03, 8'h11, 8'h12, 0);
        send_frame(8'h01, 8'h22, 8'h23, 0);
        wait_idle();
        chk("t5_ovr", ovr_seen, ovr_exp);
        chk("t5_led", led, 8'hF0);
        chk("t5_ntx", n_tx_seen, n_tx_exp);

        // BREAK aborts a partial frame and beats a simultaneous byte
        send_byte(8'hA5, 0); send_byte(8'h01, 0);
        @(posedge clk);
        #1 rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h44; pos = 0;
        @(posedge clk);
        #1 rx_break = 1'b0; rx_valid = 1'b0;
        send_byte(8'h3C, 0); send_byte(8'h3D, 0);
        repeat (20) @(posedge clk);
        chk("brk_ntx", n_tx_seen, n_tx_exp);
        chk("brk_ferr", ferr_seen, ferr_exp);
        chk("brk_led", led, 8'hF0);

        // Reset while second response byte drains
        send_frame(8'h01, 8'h55, 8'h54, 0);
        t = 0;
        while (n_tx_seen != n_tx_exp && t < 500) begin @(negedge clk); t++; end
        chk("t6_second_launch", t < 500, 1);
        chk("t6_led_written", led, 8'h55);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1; hold_ok = 0;
        #1;
        chk("t6_rst_tx_en", tx_en, 0);
        chk("t6_rst_led", led, 8'hF0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 m_reset(); reset = 1'b0;
        send_frame(8'h02, 8'h00, 8'h02, 0);
        wait_idle();
        chk("t6_ntx", n_tx_seen, n_tx_exp);
        chk("t6_led", led, 8'hF0);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 4 == 0) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h00;
                send_byte(j, int'($urandom % 3));
            end
            case ($urandom % 5)
                0: c = 8'h01;
                1: c = 8'h02;
                2: c = 8'h03;
                default: c = 8'($urandom);
            endcase
            a = 8'($urandom);
            k = c ^ a;
            if ($urandom % 4 == 0) k = k ^ 8'(1 + ($urandom % 255));
            send_frame(c, a, k, int'($urandom % 3));
            wait_idle();
            chk("rnd_led", led, m_led);
        end
        chk("end_ntx", n_tx_seen, n_tx_exp);
        chk("end_ferr", ferr_seen, ferr_exp);
        chk("end_ovr", ovr_seen, ovr_exp);
        chk("end_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
